machine_display_scheduler: RTL

Time-shares the board's 4-digit 7-segment display between the four 32-bit machine output words. It takes a tear-free snapshot of the 128-bit output bus at frame boundaries, then pages through the eight 16-bit halfwords, four hex digits at a time. It scans the digits at a fixed rate and drives the 12-bit display result. It sits between the machine core's output bus and the board pins, replacing a direct display mapping.

---
 rtl/machine_display_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/machine_display_scheduler.sv
// -----------------------------------------------------------------------------
// machine_display_scheduler
//
// Shares one 4-digit 7-segment display between the four 32-bit machine output
// words. A 128-bit snapshot of the output bus is taken only at frame
// boundaries, so a frame never shows a mix of old and new data. The eight
// 16-bit halfwords of the snapshot are shown one page at a time, four hex
// digits per page. The page moves on automatically every PAGE_DIV frames
// unless page_hold is set.
//
// Ports
//   system1000       in   1    clock
//   system1000_rstn  in   1    asynchronous reset, active low
//   outputs          in   128  machine words; word w = outputs[32w+31:32w]
//   load_valid       in   1    producer offers a new outputs value
//   load_ready       out  1    snapshot accepts outputs this cycle
//   page_hold        in   1    freeze the current page
//   result           out  12   [11:8] digit enables (bit 8 = rightmost digit),
//                              [7:0] {dp,g,f,e,d,c,b,a}; all active low
// -----------------------------------------------------------------------------
module machine_display_scheduler #(
    parameter int SCAN_DIV = 1000,  // clock cycles each digit is driven (>= 2)
    parameter int PAGE_DIV = 1024   // frames per page before auto-advance (>= 1)
) (
    input  logic         system1000,
    input  logic         system1000_rstn,
    input  logic [127:0] outputs,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         page_hold,
    output logic [11:0]  result
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    // PAGE_DIV == 1 would give a zero-width counter; keep one bit that stays 0.
    localparam int FRAME_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PAGE_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [127:0]         snapshot;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [1:0]           digit;
    logic [FRAME_W-1:0]   frame_cnt;
    logic [2:0]           page;

    logic                 scan_wrap;
    logic                 frame_end;
    logic                 capture;
    logic [15:0]          halfword;
    logic [3:0]           nibble;
    logic [11:0]          result_next;

    // Hex digit to {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        case (value)
            4'h0:    seg_decode = 7'h40;
            4'h1:    seg_decode = 7'h79;
            4'h2:    seg_decode = 7'h24;
            4'h3:    seg_decode = 7'h30;
            4'h4:    seg_decode = 7'h19;
            4'h5:    seg_decode = 7'h12;
            4'h6:    seg_decode = 7'h02;
            4'h7:    seg_decode = 7'h78;
            4'h8:    seg_decode = 7'h00;
            4'h9:    seg_decode = 7'h10;
            4'hA:    seg_decode = 7'h08;
            4'hB:    seg_decode = 7'h03;
            4'hC:    seg_decode = 7'h46;
            4'hD:    seg_decode = 7'h21;
            4'hE:    seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // The counters only run in SCAN; in IDLE they sit at their reset value.
    assign scan_wrap = (state == SCAN) && (scan_cnt == SCAN_LAST);
    assign frame_end = scan_wrap && (digit == 2'd3);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    capture    = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // Only the last cycle of a frame may accept new data, so the
                // next frame starts cleanly on the new snapshot.
                load_ready = frame_end;
                capture    = load_valid && frame_end;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot register
    // ------------------------------------------------------------------
    // NOTE: the snapshot is a plain register bank, not a RAM, so it is reset;
    // a reset must discard the previous machine state rather than redisplay it.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            snapshot <= '0;
        end else if (capture) begin
            snapshot <= outputs;
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
        end else if (state == SCAN) begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and page selection
    // ------------------------------------------------------------------
    // The frame counter keeps running while the page is held, so releasing
    // the hold advances only at the next regular wrap.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            frame_cnt <= '0;
            page      <= 3'd0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                if (!page_hold) begin
                    page <= page + 3'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display decode
    // ------------------------------------------------------------------
    // page = {word, half}, so halfword index equals page directly.
    assign halfword = snapshot[{page, 4'b0000} +: 16];
    assign nibble   = halfword[{digit, 2'b00} +: 4];

    always_comb begin
        result_next = 12'hFFF;
        if (state == SCAN) begin
            result_next[11:8] = ~(4'b0001 << digit);
            // Decimal point marks the upper halfword on the leftmost digit.
            result_next[7]    = !((digit == 2'd3) && page[0]);
            result_next[6:0]  = seg_decode(nibble);
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            result <= 12'hFFF;
        end else begin
            result <= result_next;
        end
    end

endmodule
